// File: rtl/dsm_pkg.sv
// Shared DSM definitions: vin width, sequencer state encoding and idle vin code.
package dsm_pkg;

    localparam int unsigned VIN_W = 20;
    localparam logic [VIN_W-1:0] IDLE_CODE_DEFAULT = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        RUN  = 2'd2
    } dsm_state_e;

endpackage

// File: rtl/dsm_seq_fifo.sv
// Synchronous sample FIFO with flush; a DEPTH+1-state count separates full from empty.
module dsm_seq_fifo #(
    parameter int unsigned W     = 20,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge clock) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clock) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/dsm_sample_sequencer.sv
// Paces buffered samples onto the DSM vin input once per osr clocks.
// Optional soft-start ramp enabled by defining DSM_SEQ_RAMP_EN.
module dsm_sample_sequencer #(
    parameter int unsigned           VIN_W      = dsm_pkg::VIN_W,
    parameter int unsigned           FIFO_DEPTH = 4,
    parameter logic [VIN_W-1:0]      IDLE_CODE  = dsm_pkg::IDLE_CODE_DEFAULT,
    parameter logic [VIN_W-1:0]      RAMP_STEP  = 20'h00400
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [15:0]      osr,
    input  logic             s_valid,
    input  logic [VIN_W-1:0] s_data,
    output logic             s_ready,
    output logic [VIN_W-1:0] vin,
    output logic             sample_stb,
    output logic             underrun,
    output logic             busy
);

    import dsm_pkg::*;

    dsm_state_e       state_q, state_d;
    logic [VIN_W-1:0] vin_q, vin_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             stb_q, stb_d;
    logic             underrun_q, underrun_d;

    logic             fifo_full, fifo_empty, fifo_pop, fifo_flush, fifo_push;
    logic [VIN_W-1:0] fifo_head;
    logic [15:0]      reload;
    logic             tick;

    assign reload = (osr == 16'd0) ? 16'd0 : osr - 16'd1;
    assign tick   = (cnt_q == 16'd0);

    assign s_ready   = !fifo_full;
    assign fifo_push = s_valid && !fifo_full && !fifo_flush;

    dsm_seq_fifo #(
        .W     (VIN_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (s_data),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef DSM_SEQ_RAMP_EN
    logic             ramp_up;
    logic [VIN_W-1:0] ramp_dist;
    assign ramp_up   = (fifo_head > vin_q);
    assign ramp_dist = ramp_up ? (fifo_head - vin_q) : (vin_q - fifo_head);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            vin_q      <= IDLE_CODE;
            cnt_q      <= '0;
            stb_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            vin_q      <= vin_d;
            cnt_q      <= cnt_d;
            stb_q      <= stb_d;
            underrun_q <= underrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        vin_d      = vin_q;
        cnt_d      = cnt_q;
        stb_d      = 1'b0;
        underrun_d = underrun_q;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;

        // Dropping enable outside IDLE aborts immediately, beating any tick or push.
        if (state_q != IDLE && !enable) begin
            state_d    = IDLE;
            vin_d      = IDLE_CODE;
            cnt_d      = '0;
            fifo_flush = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    vin_d = IDLE_CODE;
                    cnt_d = '0;
                    if (enable) begin
`ifdef DSM_SEQ_RAMP_EN
                        state_d = RAMP;
`else
                        state_d = RUN;
`endif
                        cnt_d      = reload;
                        underrun_d = 1'b0;
                    end
                end
`ifdef DSM_SEQ_RAMP_EN
                RAMP: begin
                    if (tick) begin
                        cnt_d = reload;
                        if (!fifo_empty) begin
                            if (ramp_dist <= RAMP_STEP) begin
                                vin_d    = fifo_head;
                                fifo_pop = 1'b1;
                                stb_d    = 1'b1;
                                state_d  = RUN;
                            end else if (ramp_up) begin
                                vin_d = vin_q + RAMP_STEP;
                            end else begin
                                vin_d = vin_q - RAMP_STEP;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
`endif
                RUN: begin
                    if (tick) begin
                        cnt_d = reload;
                        if (!fifo_empty) begin
                            vin_d    = fifo_head;
                            fifo_pop = 1'b1;
                            stb_d    = 1'b1;
                        end else begin
                            underrun_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    vin_d   = IDLE_CODE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign vin        = vin_q;
    assign sample_stb = stb_q;
    assign underrun   = underrun_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dsm_sample_sequencer.sv
// Directed self-checking bench for dsm_sample_sequencer (default build; ramp test only with DSM_SEQ_RAMP_EN).
module tb_dsm_sample_sequencer;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [15:0] osr;
    logic        s_valid;
    logic [19:0] s_data;
    logic        s_ready;
    logic [19:0] vin;
    logic        sample_stb;
    logic        underrun;
    logic        busy;

    int n_cmp;
    int n_fail;

    dsm_sample_sequencer #(
        .VIN_W      (20),
        .FIFO_DEPTH (4),
        .IDLE_CODE  (20'h00000),
        .RAMP_STEP  (20'h00400)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .osr        (osr),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .vin        (vin),
        .sample_stb (sample_stb),
        .underrun   (underrun),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0; osr = 16'd4;
        step(); step();
        n_cmp++; if (vin !== 20'h00000) begin n_fail++; $display("FAIL reset_vin got %h exp %h", vin, 20'h00000); end
        n_cmp++; if (sample_stb !== 1'b0) begin n_fail++; $display("FAIL reset_stb got %b exp 0", sample_stb); end
        n_cmp++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun got %b exp 0", underrun); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready got %b exp 1", s_ready); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic_osr4();
        logic [19:0] exp_vin;
        logic        exp_stb;
        osr = 16'd4; enable = 1'b0;
        s_valid = 1'b1; s_data = 20'h12345; step();
        s_data = 20'h0ABCD; step();
        s_valid = 1'b0; enable = 1'b1; step();
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b exp 1", busy); end
        for (int i = 1; i <= 8; i++) begin
            step();
            exp_vin = (i < 4) ? 20'h00000 : (i < 8) ? 20'h12345 : 20'h0ABCD;
            exp_stb = (i == 4) || (i == 8);
            n_cmp++; if (vin !== exp_vin) begin n_fail++; $display("FAIL basic_vin[%0d] got %h exp %h", i, vin, exp_vin); end
            n_cmp++; if (sample_stb !== exp_stb) begin n_fail++; $display("FAIL basic_stb[%0d] got %b exp %b", i, sample_stb, exp_stb); end
        end
        n_cmp++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL basic_underrun got %b exp 0", underrun); end
        enable = 1'b0; step();
        n_cmp++; if (vin !== 20'h00000) begin n_fail++; $display("FAIL basic_idle_vin got %h exp 00000", vin); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_continuous(input logic [15:0] o, input logic [19:0] base);
        int n;
        n = 0;
        osr = o; enable = 1'b0; s_valid = 1'b1;
        repeat (2) begin s_data = base + 20'(n); step(); n++; end
        enable = 1'b1; s_data = base + 20'(n); step(); n++;
        n_cmp++; if (sample_stb !== 1'b0) begin n_fail++; $display("FAIL cont_osr%0d_entry_stb got %b exp 0", o, sample_stb); end
        for (int k = 0; k < 6; k++) begin
            s_data = base + 20'(n); step(); n++;
            n_cmp++; if (vin !== base + 20'(k)) begin n_fail++; $display("FAIL cont_osr%0d_vin[%0d] got %h exp %h", o, k, vin, base + 20'(k)); end
            n_cmp++; if (sample_stb !== 1'b1) begin n_fail++; $display("FAIL cont_osr%0d_stb[%0d] got %b exp 1", o, k, sample_stb); end
            n_cmp++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL cont_osr%0d_underrun[%0d] got %b exp 0", o, k, underrun); end
        end
        enable = 1'b0; s_valid = 1'b0; step();
        n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL cont_osr%0d_flush_ready got %b exp 1", o, s_ready); end
    endtask

    task automatic test_full();
        osr = 16'd1; enable = 1'b0; s_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_data = 20'h00100 + 20'(i); step();
            n_cmp++; if (s_ready !== (i < 3)) begin n_fail++; $display("FAIL full_s_ready[%0d] got %b exp %b", i, s_ready, (i < 3)); end
        end
        s_valid = 1'b0; enable = 1'b1; step();
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++; if (vin !== 20'h00100 + 20'(k)) begin n_fail++; $display("FAIL full_order_vin[%0d] got %h exp %h", k, vin, 20'h00100 + 20'(k)); end
        end
        step();
        n_cmp++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL full_no_extra_underrun got %b exp 1", underrun); end
        n_cmp++; if (vin !== 20'h00103) begin n_fail++; $display("FAIL full_no_extra_vin got %h exp 00103", vin); end
        enable = 1'b0; step();
    endtask

    task automatic test_underrun();
        osr = 16'd2; enable = 1'b0;
        s_valid = 1'b1; s_data = 20'hAAAAA; step();
        s_valid = 1'b0; enable = 1'b1; step();
        n_cmp++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL ur_clear_on_enable got %b exp 0", underrun); end
        step();
        n_cmp++; if (sample_stb !== 1'b0) begin n_fail++; $display("FAIL ur_pre_tick_stb got %b exp 0", sample_stb); end
        step();
        n_cmp++; if (vin !== 20'hAAAAA) begin n_fail++; $display("FAIL ur_first_vin got %h exp AAAAA", vin); end
        n_cmp++; if (sample_stb !== 1'b1) begin n_fail++; $display("FAIL ur_first_stb got %b exp 1", sample_stb); end
        step(); step();
        n_cmp++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL ur_set got %b exp 1", underrun); end
        n_cmp++; if (vin !== 20'hAAAAA) begin n_fail++; $display("FAIL ur_hold_vin got %h exp AAAAA", vin); end
        n_cmp++; if (sample_stb !== 1'b0) begin n_fail++; $display("FAIL ur_empty_stb got %b exp 0", sample_stb); end
        s_valid = 1'b1; s_data = 20'h55555; step();
        s_valid = 1'b0; step();
        n_cmp++; if (vin !== 20'h55555) begin n_fail++; $display("FAIL ur_refill_vin got %h exp 55555", vin); end
        n_cmp++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL ur_sticky got %b exp 1", underrun); end
        enable = 1'b0; step();
        n_cmp++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL ur_sticky_idle got %b exp 1", underrun); end
        enable = 1'b1; step();
        n_cmp++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL ur_reenable_clear got %b exp 0", underrun); end
        enable = 1'b0; step();
    endtask

    task automatic test_no_bypass();
        osr = 16'd1; enable = 1'b1; s_valid = 1'b0; step();
        s_valid = 1'b1; s_data = 20'h77777; step();
        n_cmp++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL nobypass_underrun got %b exp 1", underrun); end
        n_cmp++; if (sample_stb !== 1'b0) begin n_fail++; $display("FAIL nobypass_stb got %b exp 0", sample_stb); end
        s_valid = 1'b0; step();
        n_cmp++; if (vin !== 20'h77777) begin n_fail++; $display("FAIL nobypass_next_vin got %h exp 77777", vin); end
        enable = 1'b0; step();
    endtask

    task automatic test_abort();
        osr = 16'd4; enable = 1'b0; s_valid = 1'b1;
        s_data = 20'h11111; step();
        s_data = 20'h22222; step();
        s_data = 20'h33333; step();
        s_valid = 1'b0; enable = 1'b1; step(); step(); step();
        enable = 1'b0; s_valid = 1'b1; s_data = 20'h44444; step();
        s_valid = 1'b0;
        n_cmp++; if (vin !== 20'h00000) begin n_fail++; $display("FAIL abort_vin got %h exp 00000", vin); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b exp 0", busy); end
        n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL abort_s_ready got %b exp 1", s_ready); end
        osr = 16'd1; enable = 1'b1; step(); step();
        n_cmp++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL abort_fifo_empty got %b exp 1", underrun); end
        enable = 1'b0; step();
        osr = 16'd4; s_valid = 1'b1;
        s_data = 20'h11111; step();
        s_data = 20'h22222; step();
        s_data = 20'h33333; step();
        s_valid = 1'b0; enable = 1'b1; step(); step();
        reset = 1'b1; s_valid = 1'b1; s_data = 20'h44444; step();
        n_cmp++; if (vin !== 20'h00000) begin n_fail++; $display("FAIL rst_mid_vin got %h exp 00000", vin); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
        n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_s_ready got %b exp 1", s_ready); end
        n_cmp++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL rst_mid_underrun got %b exp 0", underrun); end
        reset = 1'b0; s_valid = 1'b0; osr = 16'd1; step(); step();
        n_cmp++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL rst_mid_fifo_empty got %b exp 1", underrun); end
        enable = 1'b0; step();
    endtask

`ifdef DSM_SEQ_RAMP_EN
    task automatic test_ramp();
        logic [19:0] exp_vin;
        osr = 16'd1; enable = 1'b0;
        s_valid = 1'b1; s_data = 20'h01000; step();
        s_valid = 1'b0; enable = 1'b1; step();
        for (int i = 1; i <= 4; i++) begin
            step();
            exp_vin = 20'h00400 * 20'(i);
            n_cmp++; if (vin !== exp_vin) begin n_fail++; $display("FAIL ramp_vin[%0d] got %h exp %h", i, vin, exp_vin); end
            n_cmp++; if (sample_stb !== (i == 4)) begin n_fail++; $display("FAIL ramp_stb[%0d] got %b exp %b", i, sample_stb, (i == 4)); end
        end
        enable = 1'b0; step();
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
`ifdef DSM_SEQ_RAMP_EN
        test_ramp();
`else
        test_basic_osr4();
        test_continuous(16'd0, 20'h20000);
        test_continuous(16'd1, 20'h30000);
        test_full();
        test_underrun();
        test_no_bypass();
        test_abort();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
